// File: rtl/headerbit_codec_pkg.sv
// Shared baseband definitions for the header codec.
//   - HEC / whitening generator polynomials used by the baseband bit pipe
//   - bit offsets of the fields inside the 10-bit packet header
//   - packet-type codes carried in the TYPE field
//   - codec FSM state encoding
package headerbit_codec_pkg;

    localparam logic [7:0] HEC_POLY_BT = 8'hA7;   // x^8+x^7+x^5+x^2+x+1, x^8 implied
    localparam logic [6:0] WHT_POLY_BT = 7'h11;   // x^7+x^4+1, x^7 implied

    localparam int HDR_LT_ADDR_LSB = 0;
    localparam int HDR_LT_ADDR_MSB = 2;
    localparam int HDR_TYPE_LSB    = 3;
    localparam int HDR_TYPE_MSB    = 6;
    localparam int HDR_FLOW        = 7;
    localparam int HDR_ARQN        = 8;
    localparam int HDR_SEQN        = 9;

    localparam logic [3:0] PKT_NULL = 4'd0;
    localparam logic [3:0] PKT_POLL = 4'd1;
    localparam logic [3:0] PKT_FHS  = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_HEC  = 2'd2,
        ST_DONE = 2'd3
    } hb_state_e;

endpackage

// File: rtl/headerbit_codec_lfsr.sv
// Galois LFSR used for both the HEC divider and the whitening sequence.
//   clk, rst_n : clock, asynchronous active-low reset (state clears to 0)
//   load, seed : synchronous load of the register (wins over step)
//   step, din  : one Galois step; feedback = MSB ^ din into the POLY taps
//   dout       : current MSB
//   state      : current register contents
// With din tied to 0 this is a free-running scrambler; with din = MSB the
// feedback cancels and the register simply shifts left with zero fill.
module lfsr_galois
    import headerbit_codec_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    input  logic             din,
    output logic             dout,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             fb;

    always_comb begin
        fb      = state_q[WIDTH-1] ^ din;
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
            state_d = {state_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign dout  = state_q[WIDTH-1];
    assign state = state_q;

endmodule

// File: rtl/headerbit_codec.sv
// Packet-header codec: header + HEC with whitening and repetition FEC.
//   clk_6M, rstz       : clock, asynchronous active-low reset
//   p_1us              : bit-rate strobe (one clk wide)
//   start_p            : start request, honoured on p_1us while idle
//   tx_mode            : 1 = encode, 0 = decode (sampled at start)
//   abort              : synchronous abort, beats everything else
//   hec_init           : HEC seed (UAP)
//   wht_en, wht_init   : whitening enable and seed (sampled at start)
//   tx_hdr             : header to send, LSB first (sampled at start)
//   rxbit              : received coded bit, sampled on p_1us
//   txbit              : coded bit, registered, changes on p_1us
//   busy, done_p       : operation in progress / one-clk completion pulse
//   rx_hdr, hec_ok     : decoded header and HEC verdict (held)
//   fec_err_cnt        : groups with non-unanimous votes, saturating
//
// state | meaning
// IDLE  | waiting for start_p on a strobe
// HDR   | header groups, HEC divider absorbs each data bit
// HEC   | HEC groups: TX shifts remainder out, RX keeps dividing
// DONE  | one clk, done_p high, then back to IDLE
module headerbit_codec
    import headerbit_codec_pkg::*;
#(
    parameter int                  HDR_BITS = 10,
    parameter int                  HEC_BITS = 8,
    parameter logic [HEC_BITS-1:0] HEC_POLY = HEC_POLY_BT,
    parameter int                  WHT_BITS = 7,
    parameter logic [WHT_BITS-1:0] WHT_POLY = WHT_POLY_BT,
    parameter int                  REP      = 3
) (
    input  logic                clk_6M,
    input  logic                rstz,
    input  logic                p_1us,
    input  logic                start_p,
    input  logic                tx_mode,
    input  logic                abort,
    input  logic [HEC_BITS-1:0] hec_init,
    input  logic                wht_en,
    input  logic [WHT_BITS-1:0] wht_init,
    input  logic [HDR_BITS-1:0] tx_hdr,
    input  logic                rxbit,
    output logic                txbit,
    output logic                busy,
    output logic                done_p,
    output logic [HDR_BITS-1:0] rx_hdr,
    output logic                hec_ok,
    output logic [4:0]          fec_err_cnt
);

    localparam int TOTAL = HDR_BITS + HEC_BITS;
    localparam int BCW   = $clog2(TOTAL + 1);
    localparam int RCW   = (REP > 1) ? $clog2(REP) : 1;
    localparam int VCW   = $clog2(REP + 1);

    localparam logic [RCW-1:0] REP_LAST = RCW'(REP - 1);
    localparam logic [VCW-1:0] VOTE_MAJ = VCW'(REP / 2);
    localparam logic [VCW-1:0] VOTE_ALL = VCW'(REP);
    localparam logic [BCW-1:0] HDR_LAST = BCW'(HDR_BITS - 1);
    localparam logic [BCW-1:0] TOT_LAST = BCW'(TOTAL - 1);

    hb_state_e state_q, state_d;

    logic                mode_q, mode_d;
    logic [HDR_BITS-1:0] hdr_q, hdr_d;
    logic                wht_en_q, wht_en_d;
    logic [RCW-1:0]      rep_cnt_q, rep_cnt_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [VCW-1:0]      ones_q, ones_d;
    logic                txbit_q, txbit_d;
    logic [HDR_BITS-1:0] rx_hdr_q, rx_hdr_d;
    logic                hec_ok_q, hec_ok_d;
    logic [4:0]          err_q, err_d;

    logic                in_hdr, strobe_act, grp_end, grp_go, start_go;
    logic [VCW-1:0]      ones_now;
    logic                vote, unanimous, wht_bit, rx_plain, tx_plain, d_plain;
    logic                hec_msb, wht_msb;
    logic [HEC_BITS-1:0] hec_state, hec_nxt;
    logic [WHT_BITS-1:0] wht_state, wht_nxt;
    logic                tx_next_d;
    logic                unused_wht;

    assign in_hdr     = (state_q == ST_HDR);
    assign strobe_act = p_1us & ((state_q == ST_HDR) | (state_q == ST_HEC));
    assign grp_end    = strobe_act & (rep_cnt_q == REP_LAST);
    assign grp_go     = grp_end & ~abort;
    assign start_go   = start_p & p_1us & (state_q == ST_IDLE) & ~abort;

    // Majority vote over the group, including the sample arriving now.
    assign ones_now  = ones_q + VCW'(rxbit);
    assign vote      = (ones_now > VOTE_MAJ);
    assign unanimous = (ones_now == '0) | (ones_now == VOTE_ALL);

    assign wht_bit  = wht_en_q & wht_msb;
    assign rx_plain = vote ^ wht_bit;
    // Header bits come off a shift register; in HEC phase the remainder MSB
    // is sent, and feeding it back as din turns the divider into a shifter.
    assign tx_plain = in_hdr ? hdr_q[0] : hec_msb;
    assign d_plain  = mode_q ? tx_plain : rx_plain;

    lfsr_galois #(.WIDTH(HEC_BITS), .POLY(HEC_POLY)) u_hec (
        .clk   (clk_6M),
        .rst_n (rstz),
        .load  (start_go),
        .seed  (hec_init),
        .step  (grp_go),
        .din   (d_plain),
        .dout  (hec_msb),
        .state (hec_state)
    );

    lfsr_galois #(.WIDTH(WHT_BITS), .POLY(WHT_POLY)) u_wht (
        .clk   (clk_6M),
        .rst_n (rstz),
        .load  (start_go),
        .seed  (wht_init),
        .step  (grp_go),
        .din   (1'b0),
        .dout  (wht_msb),
        .state (wht_state)
    );

    // Register values after this group's step: txbit must already carry the
    // next group's coded bit on the strobe that closes the current group.
    assign hec_nxt = {hec_state[HEC_BITS-2:0], 1'b0}
                   ^ ((hec_state[HEC_BITS-1] ^ d_plain) ? HEC_POLY : '0);
    assign wht_nxt = {wht_state[WHT_BITS-2:0], 1'b0}
                   ^ (wht_state[WHT_BITS-1] ? WHT_POLY : '0);
    assign unused_wht = ^wht_nxt[WHT_BITS-2:0];

    assign tx_next_d = (in_hdr && (bit_cnt_q != HDR_LAST)) ? hdr_q[1] : hec_nxt[HEC_BITS-1];

    // State register
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_go) state_d = ST_HDR;
                ST_HDR:  if (grp_end && (bit_cnt_q == HDR_LAST)) state_d = ST_HEC;
                ST_HEC:  if (grp_end && (bit_cnt_q == TOT_LAST)) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy   = (state_q != ST_IDLE);
        done_p = (state_q == ST_DONE);
    end

    // Datapath next-state
    always_comb begin
        mode_d    = mode_q;
        hdr_d     = hdr_q;
        wht_en_d  = wht_en_q;
        rep_cnt_d = rep_cnt_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        txbit_d   = txbit_q;
        rx_hdr_d  = rx_hdr_q;
        hec_ok_d  = hec_ok_q;
        err_d     = err_q;

        if (abort) begin
            txbit_d   = 1'b0;
            rep_cnt_d = '0;
            ones_d    = '0;
        end else if (start_go) begin
            mode_d    = tx_mode;
            hdr_d     = tx_hdr;
            wht_en_d  = wht_en;
            rep_cnt_d = '0;
            bit_cnt_d = '0;
            ones_d    = '0;
            err_d     = '0;
            if (tx_mode) begin
                txbit_d = tx_hdr[0] ^ (wht_en & wht_init[WHT_BITS-1]);
            end else begin
                rx_hdr_d = '0;
                hec_ok_d = 1'b0;
            end
        end else if (strobe_act) begin
            if (grp_end) begin
                rep_cnt_d = '0;
                ones_d    = '0;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (in_hdr) begin
                    hdr_d = hdr_q >> 1;
                end
                if (mode_q) begin
                    if (bit_cnt_q == TOT_LAST) begin
                        txbit_d = 1'b0;
                    end else begin
                        txbit_d = tx_next_d ^ (wht_en_q & wht_nxt[WHT_BITS-1]);
                    end
                end else begin
                    if (!unanimous && (err_q != 5'd31)) begin
                        err_d = err_q + 5'd1;
                    end
                    if (in_hdr) begin
                        for (int i = 0; i < HDR_BITS; i++) begin
                            if (bit_cnt_q == BCW'(i)) begin
                                rx_hdr_d[i] = rx_plain;
                            end
                        end
                    end
                    if (bit_cnt_q == TOT_LAST) begin
                        hec_ok_d = (hec_nxt == '0);
                    end
                end
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
                ones_d    = ones_now;
            end
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            mode_q    <= 1'b0;
            hdr_q     <= '0;
            wht_en_q  <= 1'b0;
            rep_cnt_q <= '0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            txbit_q   <= 1'b0;
            rx_hdr_q  <= '0;
            hec_ok_q  <= 1'b0;
            err_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            hdr_q     <= hdr_d;
            wht_en_q  <= wht_en_d;
            rep_cnt_q <= rep_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            txbit_q   <= txbit_d;
            rx_hdr_q  <= rx_hdr_d;
            hec_ok_q  <= hec_ok_d;
            err_q     <= err_d;
        end
    end

    assign txbit       = txbit_q;
    assign rx_hdr      = rx_hdr_q;
    assign hec_ok      = hec_ok_q;
    assign fec_err_cnt = err_q;

endmodule

// File: tb/tb_headerbit_codec.sv
`timescale 1ns/1ps
module tb_headerbit_codec;

    localparam int HB  = 10;
    localparam int TOT = 18;

    typedef struct packed {
        logic [9:0] hdr;
        logic       ok;
        logic [4:0] err;
    } rx_exp_t;

    logic       clk_6M = 1'b0;
    logic       rstz = 1'b1;
    logic       p_1us = 1'b0;
    logic       start3 = 1'b0;
    logic       start1 = 1'b0;
    logic       tx_mode = 1'b0;
    logic       abort = 1'b0;
    logic       wht_en = 1'b0;
    logic       rxbit = 1'b0;
    logic [7:0] hec_init = '0;
    logic [6:0] wht_init = '0;
    logic [9:0] tx_hdr = '0;

    logic       txbit3, busy3, done3, hec_ok3;
    logic [9:0] rx_hdr3;
    logic [4:0] err3;
    logic       txbit1, busy1, done1, hec_ok1;
    logic [9:0] rx_hdr1;
    logic [4:0] err1;

    int sel = 3;
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    logic       txbit_s, busy_s, done_s, hec_ok_s;
    logic [9:0] rx_hdr_s;
    logic [4:0] err_s;

    logic    tx_q[$];
    rx_exp_t rx_q[$];

    always #5 clk_6M = ~clk_6M;

    headerbit_codec #(.REP(3)) u_rep3 (
        .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .start_p(start3), .tx_mode(tx_mode),
        .abort(abort), .hec_init(hec_init), .wht_en(wht_en), .wht_init(wht_init), .tx_hdr(tx_hdr),
        .rxbit(rxbit), .txbit(txbit3), .busy(busy3), .done_p(done3), .rx_hdr(rx_hdr3),
        .hec_ok(hec_ok3), .fec_err_cnt(err3)
    );

    headerbit_codec #(.REP(1)) u_rep1 (
        .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .start_p(start1), .tx_mode(tx_mode),
        .abort(abort), .hec_init(hec_init), .wht_en(wht_en), .wht_init(wht_init), .tx_hdr(tx_hdr),
        .rxbit(rxbit), .txbit(txbit1), .busy(busy1), .done_p(done1), .rx_hdr(rx_hdr1),
        .hec_ok(hec_ok1), .fec_err_cnt(err1)
    );

    assign txbit_s  = (sel == 1) ? txbit1  : txbit3;
    assign busy_s   = (sel == 1) ? busy1   : busy3;
    assign done_s   = (sel == 1) ? done1   : done3;
    assign hec_ok_s = (sel == 1) ? hec_ok1 : hec_ok3;
    assign rx_hdr_s = (sel == 1) ? rx_hdr1 : rx_hdr3;
    assign err_s    = (sel == 1) ? err1    : err3;

    always @(negedge clk_6M) if (done_s === 1'b1) done_cnt++;

    // Reference encoder: coded bit of each of the 18 groups.
    function automatic logic [TOT-1:0] encode(input logic [9:0] hdr, input logic [7:0] hi,
                                              input logic we, input logic [6:0] wi);
        logic [7:0]     h;
        logic [6:0]     w;
        logic           d, fb;
        logic [TOT-1:0] c;
        h = hi;
        w = wi;
        c = '0;
        for (int i = 0; i < TOT; i++) begin
            if (i < HB) begin
                d  = hdr[i];
                fb = h[7] ^ d;
                h  = {h[6:0], 1'b0} ^ (fb ? 8'hA7 : 8'h00);
            end else begin
                d = h[7];
                h = {h[6:0], 1'b0};
            end
            c[i] = d ^ (we & w[6]);
            w = {w[5:0], 1'b0} ^ (w[6] ? 7'h11 : 7'h00);
        end
        return c;
    endfunction

    // Reference decoder for a received stream = coded bits with sample flips.
    function automatic rx_exp_t decode(input logic [TOT-1:0] c, input logic [53:0] fl, input int rep,
                                       input logic [7:0] hi, input logic we, input logic [6:0] wi);
        rx_exp_t    r;
        logic [7:0] h;
        logic [6:0] w;
        logic       d, fb;
        int         nf;
        h = hi;
        w = wi;
        r = '0;
        for (int g = 0; g < TOT; g++) begin
            nf = 0;
            for (int k = 0; k < rep; k++) if (fl[g*rep + k]) nf++;
            d = c[g] ^ (nf > rep / 2) ^ (we & w[6]);
            if (nf != 0 && nf != rep && r.err != 5'd31) r.err = r.err + 5'd1;
            if (g < HB) r.hdr[g] = d;
            fb = h[7] ^ d;
            h  = {h[6:0], 1'b0} ^ (fb ? 8'hA7 : 8'h00);
            w  = {w[5:0], 1'b0} ^ (w[6] ? 7'h11 : 7'h00);
        end
        r.ok = (h == 8'h00);
        return r;
    endfunction

    task automatic do_start(input logic mode, input logic [9:0] hdr, input logic [7:0] hi,
                            input logic we, input logic [6:0] wi);
        @(negedge clk_6M);
        tx_mode = mode; tx_hdr = hdr; hec_init = hi; wht_en = we; wht_init = wi;
        if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
        p_1us = 1'b1;
        @(negedge clk_6M);
        start1 = 1'b0; start3 = 1'b0; p_1us = 1'b0;
    endtask

    task automatic strobe(input logic rb, input logic st, input logic ab);
        @(negedge clk_6M);
        rxbit = rb; abort = ab; p_1us = 1'b1;
        if (st) begin
            if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
        end
        @(negedge clk_6M);
        p_1us = 1'b0; abort = 1'b0; rxbit = 1'b0; start1 = 1'b0; start3 = 1'b0;
    endtask

    task automatic run_tx(input logic [9:0] hdr, input logic [7:0] hi, input logic we,
                          input logic [6:0] wi, input int rep, input logic poke);
        logic [TOT-1:0] c;
        logic           e;
        int             nb;
        c = encode(hdr, hi, we, wi);
        for (int s = 0; s < TOT*rep; s++) tx_q.push_back(c[s/rep]);
        tx_q.push_back(1'b0);
        done_cnt = 0;
        nb = 0;
        do_start(1'b1, hdr, hi, we, wi);
        e = tx_q.pop_front();
        n_cmp++;
        if (txbit_s !== e) begin
            n_bad++; $display("FAIL tx_first rep=%0d got=%b exp=%b", rep, txbit_s, e);
        end
        for (int s = 1; s <= TOT*rep; s++) begin
            if (busy_s === 1'b1) nb++;
            if (poke && s == 5) tx_hdr = ~hdr;
            strobe(1'b0, poke && (s == 5), 1'b0);
            e = tx_q.pop_front();
            n_cmp++;
            if (txbit_s !== e) begin
                n_bad++; $display("FAIL txbit rep=%0d strobe=%0d got=%b exp=%b", rep, s, txbit_s, e);
            end
        end
        n_cmp++;
        if (done_s !== 1'b1) begin
            n_bad++; $display("FAIL tx_done_after_last rep=%0d got=%b exp=1", rep, done_s);
        end
        @(negedge clk_6M);
        n_cmp++;
        if (busy_s !== 1'b0) begin
            n_bad++; $display("FAIL tx_idle_after_done rep=%0d busy=%b exp=0", rep, busy_s);
        end
        repeat (3) @(negedge clk_6M);
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++; $display("FAIL tx_done_count rep=%0d got=%0d exp=1", rep, done_cnt);
        end
        n_cmp++;
        if (nb != TOT*rep) begin
            n_bad++; $display("FAIL tx_busy_strobes rep=%0d got=%0d exp=%0d", rep, nb, TOT*rep);
        end
    endtask

    task automatic run_rx(input logic [9:0] hdr, input logic [7:0] hi, input logic we,
                          input logic [6:0] wi, input int rep, input logic [53:0] fl);
        logic [TOT-1:0] c;
        rx_exp_t        e;
        c = encode(hdr, hi, we, wi);
        rx_q.push_back(decode(c, fl, rep, hi, we, wi));
        done_cnt = 0;
        do_start(1'b0, 10'h000, hi, we, wi);
        for (int s = 1; s <= TOT*rep; s++) begin
            strobe(c[(s-1)/rep] ^ fl[s-1], 1'b0, 1'b0);
        end
        n_cmp++;
        if (done_s !== 1'b1) begin
            n_bad++; $display("FAIL rx_done rep=%0d got=%b exp=1", rep, done_s);
        end
        e = rx_q.pop_front();
        n_cmp++;
        if (rx_hdr_s !== e.hdr) begin
            n_bad++; $display("FAIL rx_hdr rep=%0d got=%h exp=%h", rep, rx_hdr_s, e.hdr);
        end
        n_cmp++;
        if (hec_ok_s !== e.ok) begin
            n_bad++; $display("FAIL rx_hec_ok rep=%0d got=%b exp=%b", rep, hec_ok_s, e.ok);
        end
        n_cmp++;
        if (err_s !== e.err) begin
            n_bad++; $display("FAIL rx_fec_err rep=%0d got=%0d exp=%0d", rep, err_s, e.err);
        end
        repeat (3) @(negedge clk_6M);
        n_cmp++;
        if ({rx_hdr_s, hec_ok_s, err_s} !== {e.hdr, e.ok, e.err}) begin
            n_bad++; $display("FAIL rx_held rep=%0d got=%h/%b/%0d exp=%h/%b/%0d", rep,
                              rx_hdr_s, hec_ok_s, err_s, e.hdr, e.ok, e.err);
        end
    endtask

    task automatic test_reset();
        #1 rstz = 1'b0;
        repeat (3) @(negedge clk_6M);
        n_cmp++;
        if ({busy3, done3, txbit3, hec_ok3, rx_hdr3, err3} !== '0) begin
            n_bad++; $display("FAIL reset_rep3 got=%h exp=0", {busy3, done3, txbit3, hec_ok3, rx_hdr3, err3});
        end
        n_cmp++;
        if ({busy1, done1, txbit1, hec_ok1, rx_hdr1, err1} !== '0) begin
            n_bad++; $display("FAIL reset_rep1 got=%h exp=0", {busy1, done1, txbit1, hec_ok1, rx_hdr1, err1});
        end
        rstz = 1'b1;
        repeat (2) @(negedge clk_6M);
    endtask

    task automatic test_tx_zero();
        sel = 3;
        run_tx(10'h000, 8'h00, 1'b0, 7'h00, 3, 1'b0);
    endtask

    task automatic test_loopback();
        sel = 3;
        run_tx(10'h2A5, 8'h47, 1'b1, 7'h55, 3, 1'b0);
        run_rx(10'h2A5, 8'h47, 1'b1, 7'h55, 3, '0);
        n_cmp++;
        if ({rx_hdr3, hec_ok3, err3} !== {10'h2A5, 1'b1, 5'd0}) begin
            n_bad++; $display("FAIL loopback_const got=%h/%b/%0d exp=2a5/1/0", rx_hdr3, hec_ok3, err3);
        end
    endtask

    task automatic test_fec_single();
        logic [53:0] fl;
        sel = 3;
        fl = '0;
        fl[0] = 1'b1; fl[10] = 1'b1; fl[29] = 1'b1; fl[36] = 1'b1; fl[52] = 1'b1;
        run_rx(10'h2A5, 8'h47, 1'b1, 7'h55, 3, fl);
        n_cmp++;
        if ({rx_hdr3, hec_ok3, err3} !== {10'h2A5, 1'b1, 5'd5}) begin
            n_bad++; $display("FAIL fec_single_const got=%h/%b/%0d exp=2a5/1/5", rx_hdr3, hec_ok3, err3);
        end
    endtask

    task automatic test_fec_double();
        logic [53:0] fl;
        sel = 3;
        fl = '0;
        fl[9] = 1'b1; fl[10] = 1'b1;
        run_rx(10'h2A5, 8'h47, 1'b1, 7'h55, 3, fl);
        n_cmp++;
        if ({rx_hdr3, hec_ok3, err3} !== {10'h2AD, 1'b0, 5'd1}) begin
            n_bad++; $display("FAIL fec_double_const got=%h/%b/%0d exp=2ad/0/1", rx_hdr3, hec_ok3, err3);
        end
    endtask

    task automatic test_abort();
        sel = 3;
        do_start(1'b1, 10'h3C1, 8'h5A, 1'b1, 7'h2B);
        for (int s = 1; s < 20; s++) strobe(1'b0, 1'b0, 1'b0);
        done_cnt = 0;
        strobe(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (busy_s !== 1'b0) begin
            n_bad++; $display("FAIL abort_busy got=%b exp=0", busy_s);
        end
        n_cmp++;
        if (txbit_s !== 1'b0) begin
            n_bad++; $display("FAIL abort_txbit got=%b exp=0", txbit_s);
        end
        strobe(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk_6M);
        n_cmp++;
        if (done_cnt != 0 || busy_s !== 1'b0) begin
            n_bad++; $display("FAIL abort_no_done done_cnt=%0d busy=%b exp=0/0", done_cnt, busy_s);
        end
        run_tx(10'h3C1, 8'h5A, 1'b1, 7'h2B, 3, 1'b0);
    endtask

    task automatic test_rep1();
        sel = 1;
        run_tx(10'h2A5, 8'h47, 1'b1, 7'h55, 1, 1'b1);
        run_rx(10'h2A5, 8'h47, 1'b1, 7'h55, 1, '0);
        n_cmp++;
        if ({hec_ok1, err1} !== {1'b1, 5'd0}) begin
            n_bad++; $display("FAIL rep1_hec got=%b/%0d exp=1/0", hec_ok1, err1);
        end
        sel = 3;
    endtask

    task automatic test_async_reset();
        sel = 3;
        do_start(1'b1, 10'h155, 8'h11, 1'b1, 7'h40);
        for (int s = 1; s <= 7; s++) strobe(1'b0, 1'b0, 1'b0);
        #2 rstz = 1'b0;
        #1;
        n_cmp++;
        if ({busy3, done3, txbit3, hec_ok3, rx_hdr3, err3} !== '0) begin
            n_bad++; $display("FAIL async_reset got=%h exp=0", {busy3, done3, txbit3, hec_ok3, rx_hdr3, err3});
        end
        @(negedge clk_6M);
        rstz = 1'b1;
        repeat (2) @(negedge clk_6M);
    endtask

    initial begin
        test_reset();
        test_tx_zero();
        test_loopback();
        test_fec_single();
        test_fec_double();
        test_abort();
        test_rep1();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
